// File: rtl/synaptic_rmw_ctrl.sv
// Initiator-side controller for the synaptic weight SRAM: read, full-word write
// and saturating signed read-modify-write of a single weight lane.
module synaptic_rmw_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TOTAL_DEPTH = 12544,
    parameter int unsigned W_BITS      = 8,
    localparam int unsigned LANES      = DATA_WIDTH / W_BITS,
    localparam int unsigned LW         = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned AW         = $clog2(TOTAL_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [AW-1:0]         req_addr,
    input  logic [LW-1:0]         req_lane,
    input  logic [W_BITS-1:0]     req_delta,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_sat,
    output logic                  rsp_err,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [AW-1:0]         SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    typedef enum logic [1:0] {IDLE, RD, MOD, WR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [W_BITS-1:0]     delta_q, delta_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  pend_sat_q, pend_sat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_sat_q, rsp_sat_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  accept;
    logic                  req_err;
    logic [W_BITS-1:0]     lane_val;
    logic [W_BITS:0]       lane_sum;
    logic                  lane_ovf;
    logic [W_BITS-1:0]     lane_new;
    logic [DATA_WIDTH-1:0] upd_word;

    // Ready is purely a function of state so an idle controller accepts immediately.
    assign req_ready = (state_q == IDLE) && !RST;
    assign accept    = req_valid && req_ready;
    assign req_err   = (32'(req_addr) >= TOTAL_DEPTH) || (32'(req_lane) >= LANES);

    // SRAM strobes decode straight from state so an async reset drops them at once.
    assign SRAM_CS = (state_q == RD) || (state_q == WR);
    assign SRAM_WE = (state_q == WR);
    assign SRAM_A  = SRAM_CS ? addr_q : '0;
    assign SRAM_D  = SRAM_WE ? word_q : '0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sat   = rsp_sat_q;
    assign rsp_err   = rsp_err_q;

    // Lane extract, widened signed add, clamp and splice back into the read word.
    always_comb begin
        lane_val = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_q == LW'(k)) begin
                lane_val = SRAM_Q[k*W_BITS +: W_BITS];
            end
        end
        lane_sum = {lane_val[W_BITS-1], lane_val} + {delta_q[W_BITS-1], delta_q};
        lane_ovf = lane_sum[W_BITS] ^ lane_sum[W_BITS-1];
        if (!lane_ovf) begin
            lane_new = lane_sum[W_BITS-1:0];
        end else if (lane_sum[W_BITS]) begin
            lane_new = {1'b1, {(W_BITS-1){1'b0}}};
        end else begin
            lane_new = {1'b0, {(W_BITS-1){1'b1}}};
        end
        upd_word = SRAM_Q;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (lane_q == LW'(k)) begin
                upd_word[k*W_BITS +: W_BITS] = lane_new;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        delta_d     = delta_q;
        word_d      = word_q;
        pend_sat_d  = pend_sat_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_sat_d   = rsp_sat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d       = req_op;
                    addr_d     = req_addr;
                    lane_d     = req_lane;
                    delta_d    = req_delta;
                    word_d     = req_wdata;
                    pend_sat_d = 1'b0;
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_sat_d   = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else if (req_op == 2'd2) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = MOD;
            MOD: begin
                if (op_q == 2'd1) begin
                    word_d     = upd_word;
                    pend_sat_d = lane_ovf;
                    state_d    = WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = SRAM_Q;
                    rsp_sat_d   = 1'b0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = word_q;
                rsp_sat_d   = pend_sat_q;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            lane_q      <= '0;
            delta_q     <= '0;
            word_q      <= '0;
            pend_sat_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_sat_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            delta_q     <= delta_d;
            word_q      <= word_d;
            pend_sat_q  <= pend_sat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sat_q   <= rsp_sat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_synaptic_rmw_ctrl.sv
// Directed self-checking bench for synaptic_rmw_ctrl with a behavioural
// single-port SRAM (registered Q, one-cycle read latency).
`timescale 1ns/1ps
module tb_synaptic_rmw_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 14;
    localparam int unsigned LW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_lane = '0;
    logic [7:0]    req_delta = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_sat;
    logic          rsp_err;
    logic          SRAM_CS;
    logic          SRAM_WE;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D;
    logic [DW-1:0] SRAM_Q = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    synaptic_rmw_ctrl dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_lane(req_lane), .req_delta(req_delta),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sat(rsp_sat), .rsp_err(rsp_err),
        .SRAM_CS(SRAM_CS), .SRAM_WE(SRAM_WE), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
        .SRAM_Q(SRAM_Q)
    );

    always #5 CLK = ~CLK;

    // SRAM model with access counters and a write log
    logic [DW-1:0] mem [0:16383];
    logic [AW-1:0] wa_log [0:63];
    logic [DW-1:0] wd_log [0:63];
    int cs_cnt = 0;
    int we_cnt = 0;
    int wr_n   = 0;

    always @(posedge CLK) begin
        if (SRAM_CS) begin
            cs_cnt = cs_cnt + 1;
            if (SRAM_WE) begin
                mem[SRAM_A] <= SRAM_D;
                if (wr_n < 64) begin
                    wa_log[wr_n] = SRAM_A;
                    wd_log[wr_n] = SRAM_D;
                end
                wr_n   = wr_n + 1;
                we_cnt = we_cnt + 1;
            end else begin
                SRAM_Q <= mem[SRAM_A];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issues one request and waits for its response; reports latency and strobe masks per cycle.
    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [LW-1:0] lane,
                          input logic [7:0] delta, input logic [DW-1:0] wdata,
                          output int lat, output logic [DW-1:0] d, output logic s, output logic e,
                          output logic [31:0] csm, output logic [31:0] wem);
        int n;
        req_op = op; req_addr = addr; req_lane = lane; req_delta = delta; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 1; csm = '0; wem = '0;
        while (!rsp_valid && lat < 20) begin
            if (SRAM_CS) csm = csm | (32'd1 << lat);
            if (SRAM_WE) wem = wem | (32'd1 << lat);
            @(posedge CLK); #1; lat++;
        end
        d = rsp_data; s = rsp_sat; e = rsp_err;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); end
        n_cmp++; if ({rsp_valid, rsp_sat, rsp_err, SRAM_CS, SRAM_WE} !== 5'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {rsp_valid, rsp_sat, rsp_err, SRAM_CS, SRAM_WE}); end
        n_cmp++; if ({rsp_data, SRAM_A, SRAM_D} !== '0) begin n_fail++;
            $display("FAIL reset_buses: got %h %h %h want 0", rsp_data, SRAM_A, SRAM_D); end
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
        @(posedge CLK); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [DW-1:0] d; logic s, e; logic [31:0] csm, wem;
        do_req(2'd2, 14'd5, 2'd0, 8'd0, 32'h7F01_80FF, lat, d, s, e, csm, wem);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d want 2", lat); end
        n_cmp++; if (wem !== 32'h2 || csm !== 32'h2) begin n_fail++; $display("FAIL wr_strobes: cs %h we %h want 2 2", csm, wem); end
        n_cmp++; if (d !== 32'h7F01_80FF || s !== 1'b0 || e !== 1'b0) begin n_fail++;
            $display("FAIL wr_rsp: got %h sat %b err %b want 7f0180ff 0 0", d, s, e); end
        n_cmp++; if (wa_log[wr_n-1] !== 14'd5 || wd_log[wr_n-1] !== 32'h7F01_80FF) begin n_fail++;
            $display("FAIL wr_sram: got a %0d d %h want 5 7f0180ff", wa_log[wr_n-1], wd_log[wr_n-1]); end
        do_req(2'd0, 14'd5, 2'd0, 8'd0, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", lat); end
        n_cmp++; if (csm !== 32'h2 || wem !== 32'h0) begin n_fail++; $display("FAIL rd_strobes: cs %h we %h want 2 0", csm, wem); end
        n_cmp++; if (d !== 32'h7F01_80FF || e !== 1'b0) begin n_fail++; $display("FAIL rd_data: got %h err %b want 7f0180ff 0", d, e); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %b want 1", req_ready); end
        @(posedge CLK); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h7F01_80FF) begin n_fail++;
            $display("FAIL rsp_hold: valid %b data %h want 0 7f0180ff", rsp_valid, rsp_data); end
        do_req(2'd3, 14'd5, 2'd0, 8'd0, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (lat !== 3 || d !== 32'h7F01_80FF) begin n_fail++; $display("FAIL op3_read: lat %0d data %h want 3 7f0180ff", lat, d); end
    endtask

    task automatic test_update();
        int lat; logic [DW-1:0] d; logic s, e; logic [31:0] csm, wem;
        do_req(2'd2, 14'd10, 2'd0, 8'd0, 32'h7F01_80FF, lat, d, s, e, csm, wem);
        do_req(2'd1, 14'd10, 2'd3, 8'd5, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL upd_latency: got %0d want 4", lat); end
        n_cmp++; if (csm !== 32'hA || wem !== 32'h8) begin n_fail++; $display("FAIL upd_strobes: cs %h we %h want a 8", csm, wem); end
        n_cmp++; if (d !== 32'h7F01_80FF || s !== 1'b1) begin n_fail++; $display("FAIL upd_pos_sat: got %h sat %b want 7f0180ff 1", d, s); end
        n_cmp++; if (wa_log[wr_n-1] !== 14'd10 || wd_log[wr_n-1] !== 32'h7F01_80FF) begin n_fail++;
            $display("FAIL upd_sram: a %0d d %h want 10 7f0180ff", wa_log[wr_n-1], wd_log[wr_n-1]); end
        do_req(2'd1, 14'd10, 2'd1, 8'd3, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (d !== 32'h7F01_83FF || s !== 1'b0) begin n_fail++; $display("FAIL upd_add: got %h sat %b want 7f0183ff 0", d, s); end
        do_req(2'd2, 14'd11, 2'd0, 8'd0, 32'h7F01_80FF, lat, d, s, e, csm, wem);
        do_req(2'd1, 14'd11, 2'd1, 8'hFF, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (d !== 32'h7F01_80FF || s !== 1'b1) begin n_fail++; $display("FAIL upd_neg_sat: got %h sat %b want 7f0180ff 1", d, s); end
        do_req(2'd1, 14'd11, 2'd0, 8'd1, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (d !== 32'h7F01_8000 || s !== 1'b0) begin n_fail++; $display("FAIL upd_wrap_lane0: got %h sat %b want 7f018000 0", d, s); end
        do_req(2'd0, 14'd11, 2'd0, 8'd0, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (d !== 32'h7F01_8000 || s !== 1'b0) begin n_fail++; $display("FAIL upd_readback: got %h sat %b want 7f018000 0", d, s); end
    endtask

    task automatic test_error();
        int lat; int cs0; logic [DW-1:0] d; logic s, e; logic [31:0] csm, wem;
        cs0 = cs_cnt;
        do_req(2'd1, 14'd12544, 2'd0, 8'd1, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL err_latency: got %0d want 1", lat); end
        n_cmp++; if (e !== 1'b1 || d !== 32'h0 || s !== 1'b0) begin n_fail++; $display("FAIL err_rsp: err %b data %h sat %b want 1 0 0", e, d, s); end
        n_cmp++; if (cs_cnt !== cs0 || csm !== 32'h0) begin n_fail++; $display("FAIL err_no_access: cs edges %0d want 0", cs_cnt - cs0); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b want 1", req_ready); end
        do_req(2'd0, 14'd16383, 2'd0, 8'd0, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (e !== 1'b1 || lat !== 1) begin n_fail++; $display("FAIL err_read_max: err %b lat %0d want 1 1", e, lat); end
        do_req(2'd0, 14'd12543, 2'd0, 8'd0, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (e !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL last_addr_ok: err %b lat %0d want 0 3", e, lat); end
    endtask

    task automatic test_reset_in_wr();
        int lat; int w0; logic [DW-1:0] d; logic s, e; logic [31:0] csm, wem;
        do_req(2'd2, 14'd20, 2'd0, 8'd0, 32'h1122_3344, lat, d, s, e, csm, wem);
        req_op = 2'd2; req_addr = 14'd20; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n_cmp++; if (SRAM_WE !== 1'b1) begin n_fail++; $display("FAIL rstwr_in_wr: WE got %b want 1", SRAM_WE); end
        w0 = we_cnt;
        #2 RST = 1'b1;
        #1;
        n_cmp++; if ({SRAM_CS, SRAM_WE, req_ready, rsp_valid} !== 4'b0) begin n_fail++;
            $display("FAIL rstwr_strobes: cs/we/ready/valid %b want 0000", {SRAM_CS, SRAM_WE, req_ready, rsp_valid}); end
        n_cmp++; if ({SRAM_A, SRAM_D, rsp_data} !== '0) begin n_fail++; $display("FAIL rstwr_buses: a %h d %h rsp %h want 0", SRAM_A, SRAM_D, rsp_data); end
        @(posedge CLK); #1;
        n_cmp++; if (we_cnt !== w0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstwr_no_write: writes %0d valid %b want 0 0", we_cnt - w0, rsp_valid); end
        RST = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstwr_ready: got %b want 1", req_ready); end
        @(posedge CLK); #1;
        do_req(2'd0, 14'd20, 2'd0, 8'd0, 32'h0, lat, d, s, e, csm, wem);
        n_cmp++; if (d !== 32'h1122_3344 || lat !== 3) begin n_fail++; $display("FAIL rstwr_old_word: got %h lat %0d want 11223344 3", d, lat); end
    endtask

    task automatic test_back_to_back();
        int lat; int w0; int i; int nr; logic acc_now;
        logic [DW-1:0] d; logic s, e; logic [31:0] csm, wem;
        int            acc_c [0:2];
        int            rsp_c [0:3];
        logic [DW-1:0] rsp_d [0:3];
        logic          rsp_s [0:3];
        logic [AW-1:0] ad  [0:2];
        logic [LW-1:0] ln  [0:2];
        logic [7:0]    dl  [0:2];
        logic [DW-1:0] exp_w [0:2];
        logic          exp_s [0:2];
        ad[0] = 14'd30; ln[0] = 2'd0; dl[0] = 8'h10; exp_w[0] = 32'h0000_0010; exp_s[0] = 1'b0;
        ad[1] = 14'd31; ln[1] = 2'd2; dl[1] = 8'h7E; exp_w[1] = 32'h017F_0304; exp_s[1] = 1'b1;
        ad[2] = 14'd32; ln[2] = 2'd3; dl[2] = 8'h01; exp_w[2] = 32'h8180_8080; exp_s[2] = 1'b0;
        do_req(2'd2, 14'd30, 2'd0, 8'd0, 32'h0000_0000, lat, d, s, e, csm, wem);
        do_req(2'd2, 14'd31, 2'd0, 8'd0, 32'h0102_0304, lat, d, s, e, csm, wem);
        do_req(2'd2, 14'd32, 2'd0, 8'd0, 32'h8080_8080, lat, d, s, e, csm, wem);
        @(posedge CLK); #1;
        w0 = wr_n; i = 0; nr = 0;
        for (int k = 0; k < 3; k++) acc_c[k] = -1;
        req_op = 2'd1; req_addr = ad[0]; req_lane = ln[0]; req_delta = dl[0]; req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid && nr < 4) begin
                rsp_c[nr] = c; rsp_d[nr] = rsp_data; rsp_s[nr] = rsp_sat; nr++;
            end
            acc_now = req_valid && req_ready;
            if (acc_now) acc_c[i] = c;
            @(posedge CLK); #1;
            if (acc_now) begin
                i++;
                if (i < 3) begin
                    req_addr = ad[i]; req_lane = ln[i]; req_delta = dl[i];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (acc_c[0] !== 0 || acc_c[1] !== 4 || acc_c[2] !== 8) begin n_fail++;
            $display("FAIL b2b_accepts: got %0d %0d %0d want 0 4 8", acc_c[0], acc_c[1], acc_c[2]); end
        n_cmp++; if (nr !== 3) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 3", nr); end
        n_cmp++; if (wr_n - w0 !== 3) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 3", wr_n - w0); end
        for (int k = 0; k < 3; k++) begin
            if (k < nr) begin
                n_cmp++; if (rsp_c[k] !== 4 * k + 4 || rsp_d[k] !== exp_w[k] || rsp_s[k] !== exp_s[k]) begin n_fail++;
                    $display("FAIL b2b_rsp%0d: cyc %0d data %h sat %b want %0d %h %b", k, rsp_c[k], rsp_d[k], rsp_s[k], 4 * k + 4, exp_w[k], exp_s[k]); end
            end
            if (w0 + k < wr_n) begin
                n_cmp++; if (wa_log[w0+k] !== ad[k] || wd_log[w0+k] !== exp_w[k]) begin n_fail++;
                    $display("FAIL b2b_sram%0d: a %0d d %h want %0d %h", k, wa_log[w0+k], wd_log[w0+k], ad[k], exp_w[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_update();
        test_error();
        test_reset_in_wr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
